phase_shift_ctrl: RTL and testbench
===================================

// Module: phase_shift_ctrl
// PURPOSE
//  Consumes shift pulses from the phase detector and turns them into PLL dynamic
//  phase-step handshakes (phasestep/updown/phasedone). It tracks the current phase
//  index modulo one clock period and flags lock after a quiet interval.
//  A one-deep manual step request path serves software-driven phase moves.
//  Sits between phasedet.shift and the PLL reconfiguration pins.
// PARAMETERS
//  STEPS     8     PLL phase steps per clock period (2..2^PHASE_W)
//  PHASE_W   3     width of phase index
//  HOLDOFF   16    settle cycles after each step before the next request is accepted (>=1)
//  WAIT_MAX  255   max cycles per handshake phase before timeout (<=255)
//  LOCK_W    10    lock counter width; locked after 2^LOCK_W-1 quiet cycles
// PORTS
//  clk              in   1        system clock
//  reset            in   1        synchronous, active-high
//  enable           in   1        1 = accept shift requests
//  shift            in   1        1-cycle request from phase detector, direction up
//  manual_step      in   1        1-cycle software step request
//  manual_dir       in   1        direction for manual_step, 1 = up, 0 = down
//  pll_phasedone    in   1        PLL done, low while stepping; synchronous to clk
//  pll_phasestep    out  1        PLL step strobe
//  pll_phaseupdown  out  1        PLL direction, 1 = up
//  phase            out  PHASE_W  current phase index, 0..STEPS-1
//  step_count       out  16       completed steps, saturates at 16'hFFFF
//  busy             out  1        1 when FSM not IDLE
//  locked           out  1        no step for 2^LOCK_W-1 enabled cycles
//  pll_err          out  1        sticky handshake-timeout flag
// BEHAVIOUR
//  Reset: all outputs 0; FSM IDLE; pending cleared. Reset wins over all inputs on the same
//   edge. Mid-step reset drops phasestep next edge; phase returns to 0, so the PLL must be
//   reset alongside.
//  FSM IDLE -> STEP -> WAIT_DONE -> HOLD -> IDLE.
//   IDLE: request is (pending manual) or manual_step or (shift && enable).
//     Priority is manual over shift; a simultaneous shift is dropped.
//     On a request, latch dir (shift = up) -> STEP. busy=1 and phasestep=1 on the next edge
//     (1-cycle latency).
//   STEP: phasestep=1, phaseupdown=dir. Leave when pll_phasedone==0 -> WAIT_DONE.
//     After WAIT_MAX cycles: pll_err=1 -> HOLD.
//   WAIT_DONE: phasestep=0. When pll_phasedone==1, update phase and step_count -> HOLD.
//     After WAIT_MAX cycles: pll_err=1 -> HOLD, phase unchanged.
//   HOLD: count HOLDOFF cycles -> IDLE.
//  Per-state timeout counter: 8 bit, cleared on each state entry.
//  Phase wrap: up at STEPS-1 -> 0; down at 0 -> STEPS-1. Arithmetic modulo STEPS, not 2^PHASE_W.
//  Requests while busy:
//   - shift is dropped.
//   - manual_step sets pending; a later one overwrites dir. Pending is served on the first
//     IDLE cycle.
//  enable=0 mid-step: the step completes normally; shifts are ignored afterwards.
//  Lock counter:
//   - counts up in IDLE when enable=1 and no request; saturates.
//   - cleared by any accepted request, by enable=0, or by timeout.
//   - locked = counter at max (registered), so it deasserts the cycle after a request is
//     accepted.
//  pll_err is cleared only by reset.
// TESTING
//  1 shift pulse in IDLE; PLL model drops phasedone 2 cycles after phasestep and raises it
//   5 cycles later -> phasestep high 3 cycles, phase 0->1, step_count=1, busy low HOLDOFF
//   cycles after phasedone rises.
//  9 spaced shift pulses, STEPS=8 -> phase ends at 1 (wrap 7->0); manual down at phase 0
//   -> phase=7, phaseupdown=0.
//  shift+manual_step(dir=0) same cycle -> exactly 1 step, down.
//  manual_step twice during a busy step (dir 1 then 0) -> exactly one further step, down.
//  PLL model never drops phasedone -> pll_err=1 after 255 STEP cycles; phase and step_count
//   unchanged; FSM returns to IDLE.
//  No requests, enable=1, LOCK_W=4 -> locked after 15 cycles; one shift -> locked=0 the next
//   cycle. Reset mid-STEP -> all outputs 0 the next cycle.

Source files
------------

// File: rtl/phase_shift_ctrl.sv
// Phase-step controller: turns phase-detector shift pulses and software step requests
// into PLL dynamic phase-step handshakes, tracking phase index, step count and lock.
module phase_shift_ctrl #(
   parameter int STEPS    = 8,
   parameter int PHASE_W  = 3,
   parameter int HOLDOFF  = 16,
   parameter int WAIT_MAX = 255,
   parameter int LOCK_W   = 10
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               enable,
   input  logic               shift,
   input  logic               manual_step,
   input  logic               manual_dir,
   input  logic               pll_phasedone,
   output logic               pll_phasestep,
   output logic               pll_phaseupdown,
   output logic [PHASE_W-1:0] phase,
   output logic [15:0]        step_count,
   output logic               busy,
   output logic               locked,
   output logic               pll_err
);

   typedef enum logic [1:0] {
      IDLE,
      STEP,
      WAIT_DONE,
      HOLD
   } state_t;

   localparam logic [PHASE_W-1:0] PHASE_MAX = PHASE_W'(STEPS - 1);
   localparam logic [PHASE_W-1:0] PHASE_ONE = PHASE_W'(1);
   localparam logic [7:0]         TMO_LAST  = 8'(WAIT_MAX - 1);
   localparam logic [7:0]         HOLD_LAST = 8'(HOLDOFF - 1);
   localparam logic [LOCK_W-1:0]  LOCK_MAX  = '1;

   state_t               state, state_next;
   logic [7:0]           timer, timer_next;
   logic                 dir, dir_next;
   logic                 pending, pending_next;
   logic                 pending_dir, pending_dir_next;
   logic [PHASE_W-1:0]   phase_next;
   logic [15:0]          step_count_next;
   logic                 err_next;
   logic [LOCK_W-1:0]    lock_cnt, lock_cnt_next;
   logic                 request;
   logic                 timeout;

   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= IDLE;
         timer       <= '0;
         dir         <= 1'b0;
         pending     <= 1'b0;
         pending_dir <= 1'b0;
         phase       <= '0;
         step_count  <= '0;
         pll_err     <= 1'b0;
         lock_cnt    <= '0;
      end else begin
         state       <= state_next;
         timer       <= timer_next;
         dir         <= dir_next;
         pending     <= pending_next;
         pending_dir <= pending_dir_next;
         phase       <= phase_next;
         step_count  <= step_count_next;
         pll_err     <= err_next;
         lock_cnt    <= lock_cnt_next;
      end
   end

   always_comb begin
      state_next       = state;
      timer_next       = timer + 8'd1;
      dir_next         = dir;
      pending_next     = pending;
      pending_dir_next = pending_dir;
      phase_next       = phase;
      step_count_next  = step_count;
      err_next         = pll_err;
      lock_cnt_next    = lock_cnt;
      request          = 1'b0;
      timeout          = 1'b0;

      case (state)
         IDLE: begin
            timer_next = '0;
            request    = pending || manual_step || (shift && enable);
            if (request) begin
               state_next   = STEP;
               pending_next = 1'b0;
               // A fresh manual request carries the newest direction; shift always steps up.
               if (manual_step)
                  dir_next = manual_dir;
               else if (pending)
                  dir_next = pending_dir;
               else
                  dir_next = 1'b1;
            end
         end
         STEP: begin
            if (!pll_phasedone) begin
               state_next = WAIT_DONE;
               timer_next = '0;
            end else if (timer == TMO_LAST) begin
               timeout    = 1'b1;
               err_next   = 1'b1;
               state_next = HOLD;
               timer_next = '0;
            end
         end
         WAIT_DONE: begin
            if (pll_phasedone) begin
               if (dir)
                  phase_next = (phase == PHASE_MAX) ? '0 : phase + PHASE_ONE;
               else
                  phase_next = (phase == '0) ? PHASE_MAX : phase - PHASE_ONE;
               if (step_count != 16'hFFFF)
                  step_count_next = step_count + 16'd1;
               state_next = HOLD;
               timer_next = '0;
            end else if (timer == TMO_LAST) begin
               timeout    = 1'b1;
               err_next   = 1'b1;
               state_next = HOLD;
               timer_next = '0;
            end
         end
         HOLD: begin
            if (timer == HOLD_LAST) begin
               state_next = IDLE;
               timer_next = '0;
            end
         end
         default: begin
            state_next = IDLE;
            timer_next = '0;
         end
      endcase

      // Software requests arriving mid-handshake are remembered, newest direction wins.
      if (state != IDLE && manual_step) begin
         pending_next     = 1'b1;
         pending_dir_next = manual_dir;
      end

      if (!enable || request || timeout)
         lock_cnt_next = '0;
      else if (state == IDLE && lock_cnt != LOCK_MAX)
         lock_cnt_next = lock_cnt + 1'b1;
   end

   assign pll_phasestep   = (state == STEP);
   assign pll_phaseupdown = dir;
   assign busy            = (state != IDLE);
   assign locked          = (lock_cnt == LOCK_MAX);

endmodule

// File: tb/tb_phase_shift_ctrl.sv
// Scoreboard bench for phase_shift_ctrl: directed requests push expected step results,
// a monitor compares them each time the controller returns to idle.
module tb_phase_shift_ctrl;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       enable = 1'b1;
   logic       shift = 1'b0;
   logic       manual_step = 1'b0;
   logic       manual_dir = 1'b0;
   logic       pll_phasedone = 1'b1;
   logic       pll_phasestep;
   logic       pll_phaseupdown;
   logic [2:0] phase;
   logic [15:0] step_count;
   logic       busy;
   logic       locked;
   logic       pll_err;

   typedef struct {
      int phase;
      int count;
      int updown;
      int err;
      int pulse;
   } exp_t;

   exp_t exp_q[$];
   exp_t e;
   int   checks = 0;
   int   failures = 0;
   bit   pll_stuck = 1'b0;

   phase_shift_ctrl #(
      .STEPS(8), .PHASE_W(3), .HOLDOFF(16), .WAIT_MAX(255), .LOCK_W(4)
   ) dut (
      .clk(clk), .reset(reset), .enable(enable), .shift(shift),
      .manual_step(manual_step), .manual_dir(manual_dir),
      .pll_phasedone(pll_phasedone), .pll_phasestep(pll_phasestep),
      .pll_phaseupdown(pll_phaseupdown), .phase(phase), .step_count(step_count),
      .busy(busy), .locked(locked), .pll_err(pll_err)
   );

   always #5 clk = ~clk;

   // PLL model: drops phasedone 2 cycles after seeing phasestep, raises it 5 cycles later.
   int pll_cnt = 0;
   bit pll_active = 1'b0;
   always @(negedge clk) begin
      if (reset) begin
         pll_active = 1'b0;
         pll_cnt = 0;
         pll_phasedone = 1'b1;
      end else if (pll_active) begin
         pll_cnt++;
         if (pll_cnt == 2)
            pll_phasedone = 1'b0;
         else if (pll_cnt == 7) begin
            pll_phasedone = 1'b1;
            pll_active = 1'b0;
         end
      end else if (pll_phasestep && !pll_stuck) begin
         pll_active = 1'b1;
         pll_cnt = 0;
      end
   end

   task automatic checkOutput(input string name, input longint actual, input longint expected);
      checks++;
      if (actual !== expected) begin
         failures++;
         $display("[TB] FAIL %s: got %0d, required %0d", name, actual, expected);
      end
   endtask

   // Monitor: a completed transaction is the busy falling edge outside reset.
   int   pulse = 0;
   logic cap_ud = 1'b0;
   logic prev_busy = 1'b0;
   always @(posedge clk) begin
      #1;
      if (reset) begin
         pulse = 0;
         prev_busy = 1'b0;
      end else begin
         if (pll_phasestep) begin
            pulse++;
            cap_ud = pll_phaseupdown;
         end
         if (prev_busy && !busy) begin
            if (exp_q.size() == 0) begin
               checks++;
               failures++;
               $display("[TB] FAIL unexpected_step: phase=%0d count=%0d, no step was required", phase, step_count);
            end else begin
               e = exp_q.pop_front();
               checkOutput("txn_phase", phase, e.phase);
               checkOutput("txn_count", step_count, e.count);
               checkOutput("txn_updown", cap_ud, e.updown);
               checkOutput("txn_err", pll_err, e.err);
               if (e.pulse >= 0)
                  checkOutput("txn_pulse", pulse, e.pulse);
            end
            pulse = 0;
         end
         prev_busy = busy;
      end
   end

   task automatic pushExp(input int ph, input int cnt, input int ud, input int err, input int pl);
      exp_t x;
      x.phase = ph; x.count = cnt; x.updown = ud; x.err = err; x.pulse = pl;
      exp_q.push_back(x);
   endtask

   // Caller is at a negedge; inputs are held across exactly one rising edge.
   task automatic applyStimulus(input logic s, input logic m, input logic md);
      shift = s;
      manual_step = m;
      manual_dir = md;
      @(negedge clk);
      shift = 1'b0;
      manual_step = 1'b0;
   endtask

   task automatic waitIdle(input int budget, input string name);
      int n = 0;
      while (busy && n < budget) begin
         @(negedge clk);
         n++;
      end
      checkOutput(name, busy, 0);
   endtask

   task automatic doReset();
      reset = 1'b1;
      shift = 1'b0;
      manual_step = 1'b0;
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;
   endtask

   initial begin
      #400000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      int n;
      enable = 1'b1;
      @(negedge clk);
      doReset();
      checkOutput("rst_phase", phase, 0);
      checkOutput("rst_count", step_count, 0);
      checkOutput("rst_busy", busy, 0);
      checkOutput("rst_locked", locked, 0);
      checkOutput("rst_err", pll_err, 0);
      checkOutput("rst_phasestep", pll_phasestep, 0);
      checkOutput("rst_updown", pll_phaseupdown, 0);

      // Lock after 15 quiet enabled cycles, then a shift drops it the next cycle.
      repeat (14) @(negedge clk);
      checkOutput("lock_at_14", locked, 0);
      @(negedge clk);
      checkOutput("lock_at_15", locked, 1);
      pushExp(1, 1, 1, 0, 3);
      applyStimulus(1'b1, 1'b0, 1'b0);
      checkOutput("lock_drop", locked, 0);
      checkOutput("step_latency_busy", busy, 1);
      checkOutput("step_latency_strobe", pll_phasestep, 1);
      n = 0;
      while (phase != 3'd1 && n < 50) begin
         @(negedge clk);
         n++;
      end
      checkOutput("first_phase", phase, 1);
      n = 0;
      while (busy && n < 100) begin
         n++;
         @(negedge clk);
      end
      checkOutput("holdoff_cycles", n, 16);

      // Nine up-steps wrap 7->0, then two manual down-steps wrap 0->7.
      doReset();
      for (int i = 1; i <= 9; i++) begin
         pushExp(i % 8, i, 1, 0, 3);
         applyStimulus(1'b1, 1'b0, 1'b0);
         waitIdle(100, "shift_idle");
      end
      checkOutput("wrap_up_phase", phase, 1);
      pushExp(0, 10, 0, 0, 3);
      applyStimulus(1'b0, 1'b1, 1'b0);
      waitIdle(100, "down1_idle");
      pushExp(7, 11, 0, 0, 3);
      applyStimulus(1'b0, 1'b1, 1'b0);
      waitIdle(100, "down2_idle");
      checkOutput("wrap_down_phase", phase, 7);
      checkOutput("wrap_down_updown", pll_phaseupdown, 0);

      // Simultaneous shift and manual down: manual wins, shift dropped.
      pushExp(6, 12, 0, 0, 3);
      applyStimulus(1'b1, 1'b1, 1'b0);
      waitIdle(100, "combo_idle");
      repeat (5) @(negedge clk);
      checkOutput("combo_single_count", step_count, 12);

      // Two manual requests while busy collapse into one pending down-step.
      pushExp(7, 13, 1, 0, 3);
      pushExp(6, 14, 0, 0, 3);
      applyStimulus(1'b1, 1'b0, 1'b0);
      repeat (2) @(negedge clk);
      applyStimulus(1'b0, 1'b1, 1'b1);
      applyStimulus(1'b0, 1'b1, 1'b0);
      waitIdle(100, "pend_first_idle");
      @(negedge clk);
      waitIdle(100, "pend_second_idle");
      repeat (5) @(negedge clk);
      checkOutput("pend_count", step_count, 14);
      checkOutput("pend_busy", busy, 0);

      // PLL never acknowledges: timeout after 255 strobe cycles, sticky error.
      pll_stuck = 1'b1;
      pushExp(6, 14, 1, 1, 255);
      applyStimulus(1'b1, 1'b0, 1'b0);
      waitIdle(400, "timeout_idle");
      checkOutput("timeout_err", pll_err, 1);
      checkOutput("timeout_phase", phase, 6);
      repeat (3) @(negedge clk);
      checkOutput("timeout_err_sticky", pll_err, 1);

      // Reset during STEP clears every output on the next edge.
      pll_stuck = 1'b0;
      applyStimulus(1'b1, 1'b0, 1'b0);
      checkOutput("midstep_started", pll_phasestep, 1);
      reset = 1'b1;
      @(negedge clk);
      checkOutput("midrst_phasestep", pll_phasestep, 0);
      checkOutput("midrst_busy", busy, 0);
      checkOutput("midrst_phase", phase, 0);
      checkOutput("midrst_count", step_count, 0);
      checkOutput("midrst_err", pll_err, 0);
      checkOutput("midrst_updown", pll_phaseupdown, 0);
      checkOutput("midrst_locked", locked, 0);
      @(negedge clk);
      reset = 1'b0;

      repeat (5) @(negedge clk);
      checkOutput("scoreboard_drained", exp_q.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
